// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
//   Shared types and helpers for the PLL reset sequencer.
//   - pll_seq_state_t : sequencer state encoding
//   - RETRY_W         : width of the retry counter / retry_cnt output
//   - cnt_width()     : width of the shared phase counter, sized so the
//                       largest terminal count (max parameter - 1) fits
//   - sat_inc8()      : saturating 8-bit increment used by event counters
// -----------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int RETRY_W = 8;

    // The counter only ever reaches (largest count - 1), so $clog2 of the
    // largest count is enough; a floor of one bit keeps the vector legal.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   STAGES-deep flip-flop synchronizer for a single asynchronous level.
//   Resets to 0 so a PLL that was locked before reset is not trusted until
//   the flag has propagated through the full chain again.
//   Ports:
//     clk : destination clock
//     rst : asynchronous active-high reset
//     d   : asynchronous input level
//     q   : synchronized level, STAGES clock edges of latency
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//   Brings up the board PLL and gates the system reset on a qualified lock.
//   Sequence: pulse pll_rst -> wait for lock (with timeout and bounded
//   retries) -> require a run of consecutive locked cycles -> release
//   sys_rst. Lock loss while running, or relock_req at any time, restarts
//   the sequence. Retries exhausted parks the block in FAIL with the PLL
//   held in reset until relock_req or rst.
//
//   Ports:
//     refclk     in   reference clock, sole clock
//     rst        in   asynchronous active-high reset
//     pll_rst    out  PLL reset (high in RESET_PLL and FAIL)
//     pll_locked in   PLL lock flag, asynchronous to refclk
//     relock_req in   single-cycle request to restart the sequence
//     sys_rst    out  system reset, low only while running
//     ready      out  high only while running
//     fail       out  high while parked after exhausting retries
//     lock_lost  out  one-cycle pulse when lock drops while running
//     retry_cnt  out  [7:0] extra attempts used in the current sequence
//     loss_count out  [7:0] saturating lock-loss event count
//                     (present only when PLL_LOSS_COUNTER_EN is defined)
//
//   Build option: define PLL_LOSS_COUNTER_EN to add loss_count.
// -----------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    output logic       pll_rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
`ifdef PLL_LOSS_COUNTER_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                     LOCK_STABLE_CYCLES);

    // Terminal counts: a phase ends on the cycle its counter reaches N-1.
    localparam logic [CNT_W-1:0]   PULSE_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    logic                 locked_s;
    pll_seq_state_t       state_r;
    pll_seq_state_t       state_nxt_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_nxt_s;
    logic [RETRY_W-1:0]   retry_r;
    logic [RETRY_W-1:0]   retry_nxt_s;
    logic                 lock_lost_nxt_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state, phase counter, retry counter and lock-loss decode.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        retry_nxt_s     = retry_r;
        lock_lost_nxt_s = 1'b0;

        if (relock_req) begin
            // Explicit request wins over timeout and lock loss, and is not
            // itself reported as a lock loss.
            state_nxt_s = RESET_PLL;
            cnt_nxt_s   = '0;
            retry_nxt_s = '0;
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (cnt_r == PULSE_LAST) begin
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt_s = STABLE;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cnt_nxt_s = '0;
                        if (retry_r == RETRY_LIMIT) begin
                            state_nxt_s = FAIL;
                        end else begin
                            state_nxt_s = RESET_PLL;
                            retry_nxt_s = retry_r + RETRY_W'(1);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end

                STABLE: begin
                    if (!locked_s) begin
                        // A glitch restarts lock acquisition without
                        // consuming a retry.
                        state_nxt_s = WAIT_LOCK;
                        cnt_nxt_s   = '0;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = '0;
                        retry_nxt_s = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end

                RUN: begin
                    cnt_nxt_s = '0;
                    if (!locked_s) begin
                        state_nxt_s     = RESET_PLL;
                        retry_nxt_s     = '0;
                        lock_lost_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end

                FAIL: begin
                    state_nxt_s = FAIL;
                    cnt_nxt_s   = '0;
                end

                default: begin
                    state_nxt_s = RESET_PLL;
                    cnt_nxt_s   = '0;
                    retry_nxt_s = '0;
                end
            endcase
        end
    end

    // Sequencer state, phase counter and retry counter registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r <= RESET_PLL;
            cnt_r   <= '0;
            retry_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            retry_r <= retry_nxt_s;
        end
    end

    // Output registers decoded from the next state so each output is a flop
    // that lines up with the state it describes.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            pll_rst   <= (state_nxt_s == RESET_PLL) || (state_nxt_s == FAIL);
            sys_rst   <= (state_nxt_s != RUN);
            ready     <= (state_nxt_s == RUN);
            fail      <= (state_nxt_s == FAIL);
            lock_lost <= lock_lost_nxt_s;
        end
    end

    assign retry_cnt = retry_r;

`ifdef PLL_LOSS_COUNTER_EN
    // Lock-loss event counter; survives relock_req, cleared only by rst.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_count <= 8'd0;
        end else if (lock_lost_nxt_s) begin
            loss_count <= sat_inc8(loss_count);
        end else begin
            loss_count <= loss_count;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//   Directed scenarios plus a randomized soak for pll_reset_sequencer.
//   A behavioural model (phase + elapsed-cycle count, lock flag delayed by a
//   queue) predicts every output after every refclk edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int P     = 4;
    localparam int T     = 32;
    localparam int S     = 8;
    localparam int MAXR  = 2;
    localparam int NSYNC = 2;

    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAIL   = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [7:0] retry_cnt;
`ifdef PLL_LOSS_COUNTER_EN
    logic [7:0] loss_count;
`endif

    always #5 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (MAXR),
        .SYNC_STAGES         (NSYNC)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_rst    (pll_rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
`ifdef PLL_LOSS_COUNTER_EN
        ,
        .loss_count (loss_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    int m_ph;
    int m_n;       // cycles already spent in the current phase
    int m_retry;
    int m_loss;
    bit m_lost;
    bit m_q[$];    // pll_locked samples still travelling through the synchronizer

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph    = PH_PULSE;
        m_n     = 0;
        m_retry = 0;
        m_loss  = 0;
        m_lost  = 1'b0;
        m_q     = {};
        for (int i = 0; i < NSYNC; i++) m_q.push_back(1'b0);
    endtask

    // One refclk edge of the reference behaviour.
    task automatic model_edge();
        bit ls;
        if (rst) begin
            model_reset();
            return;
        end
        ls = m_q.pop_front();
        m_q.push_back(pll_locked);
        m_lost = 1'b0;
        if (relock_req) begin
            m_ph = PH_PULSE; m_n = 0; m_retry = 0;
            return;
        end
        case (m_ph)
            PH_PULSE: begin
                // pll_rst lasts P cycles
                if (m_n + 1 == P) begin m_ph = PH_WAIT; m_n = 0; end
                else m_n++;
            end
            PH_WAIT: begin
                if (ls) begin m_ph = PH_STABLE; m_n = 0; end
                else if (m_n + 1 == T) begin
                    m_n = 0;
                    if (m_retry == MAXR) m_ph = PH_FAIL;
                    else begin m_retry++; m_ph = PH_PULSE; end
                end
                else m_n++;
            end
            PH_STABLE: begin
                if (!ls) begin m_ph = PH_WAIT; m_n = 0; end
                else if (m_n + 1 == S) begin m_ph = PH_RUN; m_n = 0; m_retry = 0; end
                else m_n++;
            end
            PH_RUN: begin
                if (!ls) begin
                    m_lost = 1'b1; m_ph = PH_PULSE; m_n = 0; m_retry = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk_all();
        chk("pll_rst",   pll_rst,   (m_ph == PH_PULSE) || (m_ph == PH_FAIL));
        chk("sys_rst",   sys_rst,   m_ph != PH_RUN);
        chk("ready",     ready,     m_ph == PH_RUN);
        chk("fail",      fail,      m_ph == PH_FAIL);
        chk("lock_lost", lock_lost, m_lost);
        chk("retry_cnt", retry_cnt, m_retry);
`ifdef PLL_LOSS_COUNTER_EN
        chk("loss_count", loss_count, m_loss);
`endif
    endtask

    task automatic tick();
        @(posedge refclk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic relock_pulse();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
    endtask

    initial begin
        int k;
        int h;
        int lo;
        int nwait;
        bit prev;
        bit saw_rst;

        rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
        model_reset();
        tick();
        tick();
        chk("reset_pll_rst", pll_rst, 1'b1);
        chk("reset_sys_rst", sys_rst, 1'b1);
        rst = 1'b0;

        // 1. Nominal bring-up.
        k = 0;
        while (pll_rst === 1'b1 && k < 50) begin tick(); k++; end
        chk("t1_pulse_len", k, P);
        repeat (10) tick();
        pll_locked = 1'b1;
        tick();                           // edge that first captures the lock
        k = 0;
        while (ready !== 1'b1 && k < 100) begin tick(); k++; end
        chk("t1_ready_latency", k, NSYNC + S);
        chk("t1_sys_rst", sys_rst, 1'b0);
        chk("t1_retry", retry_cnt, 0);

        // 4. Lock loss while running.
        repeat ($urandom_range(3, 20)) tick();
        pll_locked = 1'b0;
        k = 0;
        while (lock_lost !== 1'b1 && k < 20) begin tick(); k++; end
        chk("t4_lost_latency", k, NSYNC + 1);
        chk("t4_sys_rst", sys_rst, 1'b1);
        chk("t4_ready", ready, 1'b0);
        tick();
        chk("t4_lost_one_cycle", lock_lost, 1'b0);
        h = 1;
        while (pll_rst === 1'b1 && h < 50) begin tick(); h++; end
        chk("t4_pulse_len", h, P);
        repeat ($urandom_range(2, 20)) tick();
        pll_locked = 1'b1;
        k = 0;
        while (ready !== 1'b1 && k < 100) begin tick(); k++; end
        chk("t4_relocked", ready, 1'b1);
`ifdef PLL_LOSS_COUNTER_EN
        chk("t4_loss_count", loss_count, 8'd1);
`endif

        // 5. relock_req in the same cycle the lock loss is seen.
        repeat ($urandom_range(2, 10)) tick();
        pll_locked = 1'b0;
        tick();
        tick();
        relock_pulse();
        chk("t5_lock_lost", lock_lost, 1'b0);
        chk("t5_pll_rst", pll_rst, 1'b1);
`ifdef PLL_LOSS_COUNTER_EN
        chk("t5_loss_count", loss_count, 8'd1);
`endif
        repeat ($urandom_range(6, 20)) tick();
        pll_locked = 1'b1;
        k = 0;
        while (ready !== 1'b1 && k < 100) begin tick(); k++; end
        chk("t5_relocked", ready, 1'b1);

        // 3. Glitch while qualifying lock.
        pll_locked = 1'b0;
        relock_pulse();
        k = 0;
        while (pll_rst === 1'b1 && k < 50) begin tick(); k++; end
        repeat ($urandom_range(3, 10)) tick();
        saw_rst = 1'b0;
        pll_locked = 1'b1;
        repeat (5) begin tick(); saw_rst |= pll_rst; end
        pll_locked = 1'b0;
        tick(); saw_rst |= pll_rst;
        pll_locked = 1'b1;
        tick(); saw_rst |= pll_rst;
        chk("t3_no_early_ready", ready, 1'b0);
        k = 0;
        while (ready !== 1'b1 && k < 100) begin tick(); k++; saw_rst |= pll_rst; end
        chk("t3_ready_latency", k, NSYNC + S);
        chk("t3_no_pll_rst", saw_rst, 1'b0);
        chk("t3_retry", retry_cnt, 0);

        // 2. Never lock: retries then FAIL.
        pll_locked = 1'b0;
        relock_pulse();
        h = 1; lo = 0; nwait = 0;
        for (int i = 0; i < 400 && fail !== 1'b1; i++) begin
            prev = pll_rst;
            tick();
            if (pll_rst !== prev) begin
                if (prev) begin
                    chk("t2_pulse_len", h, P);
                    chk("t2_retry_step", retry_cnt, nwait);
                    lo = 1;
                end else begin
                    chk("t2_wait_len", lo, T);
                    nwait++;
                    h = 1;
                end
            end else if (pll_rst) h++;
            else lo++;
        end
        chk("t2_fail", fail, 1'b1);
        chk("t2_attempts", nwait, MAXR + 1);
        chk("t2_retry_final", retry_cnt, MAXR);
        repeat (5) tick();
        chk("t2_fail_held", fail, 1'b1);
        chk("t2_pll_rst_held", pll_rst, 1'b1);
        relock_pulse();
        chk("t2_fail_cleared", fail, 1'b0);
        chk("t2_restart_retry", retry_cnt, 0);

        // Randomized soak against the model.
        for (int it = 0; it < 40; it++) begin
            pll_locked = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) relock_pulse();
            repeat ($urandom_range(1, 45)) tick();
        end

        // 6. Asynchronous reset mid WAIT_LOCK with retry_cnt = 1.
        pll_locked = 1'b0;
        relock_pulse();
        k = 0;
        while (!(retry_cnt === 8'd1 && pll_rst === 1'b0) && k < 200) begin tick(); k++; end
        repeat (5) tick();
        chk("t6_pre_retry", retry_cnt, 8'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_async_pll_rst", pll_rst, 1'b1);
        chk("t6_async_sys_rst", sys_rst, 1'b1);
        chk("t6_async_retry", retry_cnt, 8'd0);
        chk_all();
        tick();
        rst = 1'b0;
        repeat (P + 3) tick();
        pll_locked = 1'b1;
        k = 0;
        while (ready !== 1'b1 && k < 100) begin tick(); k++; end
        chk("t6_restart_ready", ready, 1'b1);
        chk("t6_restart_retry", retry_cnt, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
